display_message_scheduler: RTL and testbench

DISPLAY_MESSAGE_SCHEDULER -- requirements
Module: display_message_scheduler

---
 rtl/display_message_scheduler_pkg.sv | 13 +
 rtl/display_message_scheduler_if.sv | 27 ++
 rtl/display_message_scheduler_rr_arbiter.sv | 29 ++
 rtl/display_message_scheduler.sv | 105 ++++++++++
 tb/tb_display_message_scheduler.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/display_message_scheduler_pkg.sv
// display_message_scheduler_pkg: shared FSM encoding and timing defaults for the message scheduler
package display_message_scheduler_pkg;
  localparam int BITS_PER_ASCII_DIGIT = 8;
  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_BUF_BITS = 10 * BITS_PER_ASCII_DIGIT;
  localparam int DEFAULT_TICKS_PER_DIGIT = 50000000;
  localparam int DEFAULT_SCROLL_DIGITS = 20;
  localparam int DEFAULT_STATIC_DIGITS = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SHOW = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/display_message_scheduler_if.sv
// display_message_scheduler_if: requester and display signals of the message scheduler
//   master: requester side (drives req, req_string, req_scroll)
//   slave : scheduler side (drives grant, done, busy and the display outputs)
interface display_message_scheduler_if
  import display_message_scheduler_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int BUF_BITS = DEFAULT_BUF_BITS
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*BUF_BITS-1:0] req_string;
  logic [NUM_REQ-1:0] req_scroll;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic busy;
  logic [BUF_BITS-1:0] asciiStringToDisplay;
  logic needToScroll;
  logic latchNewString;
  modport master (
    output req, req_string, req_scroll,
    input grant, done, busy, asciiStringToDisplay, needToScroll, latchNewString
  );
  modport slave (
    input req, req_string, req_scroll,
    output grant, done, busy, asciiStringToDisplay, needToScroll, latchNewString
  );
endinterface

// File: rtl/display_message_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin pick of the lowest requesting index at or above rrPtr (wrapping)
//   req    : request vector
//   rrPtr  : index with highest priority this round
//   winner : one-hot selected requester
//   valid  : any request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      rrPtr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);
  int idx;
  // Scan from farthest to nearest so the nearest requester after rrPtr wins.
  always_comb begin
    winner = '0;
    idx = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rrPtr) + i) % NUM_REQ;
      if (req[idx]) begin
        winner = '0;
        winner[idx] = 1'b1;
      end
    end
  end
  assign valid = |req;
endmodule

// File: rtl/display_message_scheduler.sv
// display_message_scheduler: shares one scrolling display among several requesters
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : requester inputs (req, req_string, req_scroll), grant/done/busy, and
//           display outputs (asciiStringToDisplay, needToScroll, latchNewString)
module display_message_scheduler
  import display_message_scheduler_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int BUF_BITS = DEFAULT_BUF_BITS,
  parameter int TICKS_PER_DIGIT = DEFAULT_TICKS_PER_DIGIT,
  parameter int SCROLL_DIGITS = DEFAULT_SCROLL_DIGITS,
  parameter int STATIC_DIGITS = DEFAULT_STATIC_DIGITS
) (
  input logic clk,
  input logic reset,
  display_message_scheduler_if.slave bus
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int TW = TICKS_PER_DIGIT > 1 ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int MAXD = SCROLL_DIGITS > STATIC_DIGITS ? SCROLL_DIGITS : STATIC_DIGITS;
  localparam int DW = $clog2(MAXD) > 5 ? $clog2(MAXD) : 5;

  logic [1:0] state;
  logic [PW-1:0] rrPtr, winIdx, selIdx, nextPtr;
  logic [NUM_REQ-1:0] selOneHot, grant;
  logic selValid, held, tickWrap, expire;
  logic [TW-1:0] tick;
  logic [DW-1:0] digit;
  logic [BUF_BITS-1:0] strReg;
  logic scrollReg;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .req(bus.req),
    .rrPtr(rrPtr),
    .winner(selOneHot),
    .valid(selValid)
  );

  always_comb begin
    selIdx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (selOneHot[i]) selIdx = PW'(i);
  end

  // The owner must keep its request up through LOAD and SHOW, else the message is aborted.
  assign held = |(bus.req & grant);
  assign tickWrap = tick == TW'(TICKS_PER_DIGIT - 1);
  assign expire = tickWrap && digit == (scrollReg ? DW'(SCROLL_DIGITS - 1) : DW'(STATIC_DIGITS - 1));
  assign nextPtr = winIdx == PW'(NUM_REQ - 1) ? '0 : winIdx + PW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      rrPtr <= '0;
      winIdx <= '0;
      grant <= '0;
      tick <= '0;
      digit <= '0;
      strReg <= '0;
      scrollReg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (selValid) begin
          state <= ST_LOAD;
          grant <= selOneHot;
          winIdx <= selIdx;
          strReg <= bus.req_string[selIdx*BUF_BITS +: BUF_BITS];
          scrollReg <= bus.req_scroll[selIdx];
        end
        ST_LOAD: if (!held) begin
          state <= ST_IDLE;
          grant <= '0;
          rrPtr <= nextPtr;
        end else begin
          state <= ST_SHOW;
          tick <= '0;
          digit <= '0;
        end
        ST_SHOW: if (!held) begin
          state <= ST_IDLE;
          grant <= '0;
          rrPtr <= nextPtr;
        end else if (expire) begin
          state <= ST_DONE;
        end else begin
          tick <= tickWrap ? '0 : tick + TW'(1);
          digit <= digit + DW'(tickWrap);
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          rrPtr <= nextPtr;
        end
      endcase
    end
  end

  assign bus.grant = grant;
  assign bus.done = state == ST_DONE ? grant : '0;
  assign bus.busy = state != ST_IDLE;
  assign bus.latchNewString = state == ST_LOAD;
  assign bus.asciiStringToDisplay = strReg;
  assign bus.needToScroll = scrollReg;
endmodule

// File: tb/tb_display_message_scheduler.sv
// tb_display_message_scheduler: directed table-driven bench for display_message_scheduler
module tb_display_message_scheduler;
  typedef struct {
    logic [3:0] req;
    logic [3:0] scroll;
    int doneCycle;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [79:0] strs [4];
  logic [79:0] altStr;
  vec_t vecs [4];

  display_message_scheduler_if #(.NUM_REQ(4), .BUF_BITS(80)) bus ();

  display_message_scheduler #(
    .NUM_REQ(4), .BUF_BITS(80), .TICKS_PER_DIGIT(4), .SCROLL_DIGITS(20), .STATIC_DIGITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic loadStrings();
    for (int i = 0; i < 4; i++) bus.req_string[i*80 +: 80] = strs[i];
  endtask

  initial begin
    int idx;
    int doneAt;
    strs[0] = "    1234";
    strs[1] = "HELLO     ";
    strs[2] = "SCROLL TXT";
    strs[3] = "ALARM  333";
    altStr = "CHANGED!!!";
    vecs[0] = '{4'b0001, 4'b0000, 18};
    vecs[1] = '{4'b0100, 4'b0100, 82};
    vecs[2] = '{4'b1000, 4'b0000, 18};
    vecs[3] = '{4'b0010, 4'b0010, 82};
    bus.req = '0;
    bus.req_scroll = '0;
    loadStrings();
    repeat (2) @(negedge clk);
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_latch", bus.latchNewString, 0);
    check("rst_string", bus.asciiStringToDisplay, 0);
    #2 reset = 1'b1;

    // Single-requester services with hand-computed completion cycles.
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      bus.req = vecs[v].req;
      bus.req_scroll = vecs[v].scroll;
      idx = 0;
      for (int i = 0; i < 4; i++) if (vecs[v].req[i]) idx = i;
      @(negedge clk);
      check($sformatf("v%0d_latch", v), bus.latchNewString, 1);
      check($sformatf("v%0d_grant", v), bus.grant, vecs[v].req);
      check($sformatf("v%0d_string", v), bus.asciiStringToDisplay, strs[idx]);
      check($sformatf("v%0d_scroll", v), bus.needToScroll, vecs[v].scroll[idx]);
      doneAt = -1;
      for (int c = 2; c <= 100 && doneAt < 0; c++) begin
        @(negedge clk);
        if (c == 5) bus.req_string[idx*80 +: 80] = altStr;
        if (bus.done != 0) begin
          doneAt = c;
          check($sformatf("v%0d_done_val", v), bus.done, vecs[v].req);
          check($sformatf("v%0d_string_held", v), bus.asciiStringToDisplay, strs[idx]);
          check($sformatf("v%0d_scroll_held", v), bus.needToScroll, vecs[v].scroll[idx]);
          bus.req = '0;
        end
      end
      check($sformatf("v%0d_done_cycle", v), doneAt, vecs[v].doneCycle);
      bus.req = '0;
      @(negedge clk);
      check($sformatf("v%0d_idle_busy", v), bus.busy, 0);
      check($sformatf("v%0d_idle_grant", v), bus.grant, 0);
      loadStrings();
    end

    // Reset asserted in the middle of SHOW.
    @(negedge clk);
    bus.req = 4'b0100;
    bus.req_scroll = '0;
    repeat (10) @(negedge clk);
    check("rs_busy_before", bus.busy, 1);
    #2 reset = 1'b0;
    #1;
    check("rs_grant", bus.grant, 0);
    check("rs_done", bus.done, 0);
    check("rs_busy", bus.busy, 0);
    check("rs_latch", bus.latchNewString, 0);
    check("rs_scroll", bus.needToScroll, 0);
    check("rs_string", bus.asciiStringToDisplay, 0);
    bus.req = '0;
    @(negedge clk);
    check("rs_done_after", bus.done, 0);
    #2 reset = 1'b1;
    @(negedge clk);
    bus.req = 4'b1000;
    @(negedge clk);
    check("rs_latch_c1", bus.latchNewString, 1);
    check("rs_grant_c1", bus.grant, 4'b1000);
    bus.req = '0;
    @(negedge clk);
    check("rs_abort_busy", bus.busy, 0);

    // All requesters held: round-robin order 0,1,2,3,0 with one idle cycle between.
    @(negedge clk);
    bus.req = 4'b1111;
    for (int c = 1; c <= 77; c++) begin
      @(negedge clk);
      if (c % 19 == 1) begin
        check($sformatf("rr_latch_c%0d", c), bus.latchNewString, 1);
        check($sformatf("rr_grant_c%0d", c), bus.grant, 4'b0001 << ((c / 19) % 4));
      end
      if (c % 19 == 18) check($sformatf("rr_done_c%0d", c), bus.done, 4'b0001 << ((c / 19) % 4));
      if (c % 19 == 0) check($sformatf("rr_idle_c%0d", c), bus.busy, 0);
    end
    bus.req = '0;
    @(negedge clk);
    check("rr_abort_busy", bus.busy, 0);

    // Owner drops its request at SHOW cycle 5: silent abort, pointer advances past it.
    @(negedge clk);
    bus.req = 4'b0010;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) check("ab_grant", bus.grant, 4'b0010);
      check($sformatf("ab_nodone_c%0d", c), bus.done, 0);
      if (c == 6) bus.req = '0;
      if (c == 7) begin
        check("ab_grant_clr", bus.grant, 0);
        check("ab_busy_clr", bus.busy, 0);
        check("ab_string", bus.asciiStringToDisplay, strs[1]);
      end
    end
    bus.req = 4'b0011;
    @(negedge clk);
    check("ab_ptr_winner", bus.grant, 4'b0001);
    bus.req = '0;
    @(negedge clk);
    check("ab_end_busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
